// File: rtl/scan_frame_packer_pkg.sv
// Shared constants, record layout and serializer state encoding for the scan frame packer.
package scan_frame_pkg;

  localparam logic [7:0]  FRAME_HDR = 8'hA5;
  localparam int unsigned FRAME_LEN = 9;
  localparam int unsigned FLAG_HIT  = 0;
  localparam int unsigned FLAG_DROP = 1;
  localparam int unsigned FLAGS_W   = 8;
  localparam int unsigned SCAN_ID_W = 16;
  localparam int unsigned REC_W     = FLAGS_W + SCAN_ID_W + 32;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } ser_state_e;

  function automatic int unsigned rec_width(int unsigned id_w, int unsigned ts_w);
    return FLAGS_W + id_w + ts_w;
  endfunction

endpackage

// File: rtl/scan_frame_packer_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is always visible on rd_data_o.
module scan_record_fifo #(
  parameter int unsigned WIDTH = 56,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign full_o    = (level_o == DEPTH_L);
  assign empty_o   = (level_o == '0);
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/scan_frame_packer.sv
// Snapshots each finished scan into a record FIFO and serializes records as 9-byte
// frames (A5, flags, scan_id, sig_time, XOR checksum) on a byte valid/ready stream.
module scan_frame_packer
  import scan_frame_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TS_W       = 32,
  parameter int unsigned ID_W       = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sync_start,
  input  logic                          sig_edge,
  input  logic [TS_W-1:0]               sig_time,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_count,
  output logic                          overflow
);

  localparam int unsigned RW = rec_width(ID_W, TS_W);

  logic              sig_prev_q, sync_d_q, armed_q;
  logic              hit_q, hit_d;
  logic              pend_drop_q, pend_drop_d;
  logic              overflow_q, overflow_d;
  logic [ID_W-1:0]   scan_id_q, scan_id_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              rise, snap, push, pop, full, empty;
  logic [7:0]        flags;
  logic [RW-1:0]     push_rec, pop_rec;
  ser_state_e        state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [63:0]       body_q, body_d;
  logic [7:0]        csum, tx_byte;

  assign rise = sig_edge & ~sig_prev_q;
  // sync_d marks the snapshot cycle; by then hit_q already holds an edge coincident with sync_start.
  assign snap = sync_d_q & armed_q;

  always_comb begin
    hit_d            = sync_d_q ? rise : (hit_q | rise);
    flags            = '0;
    flags[FLAG_HIT]  = hit_q;
    flags[FLAG_DROP] = pend_drop_q;
    push             = snap & ~full;
    push_rec         = {flags, scan_id_q, sig_time};
    scan_id_d        = snap ? scan_id_q + ID_W'(1) : scan_id_q;
    drop_cnt_d       = drop_cnt_q;
    overflow_d       = overflow_q;
    pend_drop_d      = pend_drop_q;
    if (snap && full) begin
      drop_cnt_d  = (drop_cnt_q == '1) ? drop_cnt_q : drop_cnt_q + 16'd1;
      overflow_d  = 1'b1;
      pend_drop_d = 1'b1;
    end else if (push) begin
      pend_drop_d = 1'b0;
    end
  end

  scan_record_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (reset),
    .push_i    (push),
    .wr_data_i (push_rec),
    .pop_i     (pop),
    .rd_data_o (pop_rec),
    .full_o    (full),
    .empty_o   (empty),
    .level_o   (fifo_level)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    body_d   = body_q;
    pop      = 1'b0;
    tx_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          body_d  = {FRAME_HDR, pop_rec[RW-1 -: FLAGS_W], 16'(pop_rec[TS_W +: ID_W]),
                     32'(pop_rec[TS_W-1:0])};
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          if (idx_q == 4'(FRAME_LEN - 1)) state_d = ST_IDLE;
          else                            idx_d   = idx_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    csum = '0;
    for (int unsigned i = 0; i < 8; i++) csum ^= body_q[8*i +: 8];
    tx_byte = csum;
    for (int unsigned i = 0; i < 8; i++) begin
      if (idx_q == 4'(i)) tx_byte = body_q[8*(7-i) +: 8];
    end
    tx_data = (state_q == ST_SEND) ? tx_byte : '0;
  end

  assign drop_count = drop_cnt_q;
  assign overflow   = overflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_prev_q  <= 1'b0;
      sync_d_q    <= 1'b0;
      armed_q     <= 1'b0;
      hit_q       <= 1'b0;
      pend_drop_q <= 1'b0;
      overflow_q  <= 1'b0;
      scan_id_q   <= '0;
      drop_cnt_q  <= '0;
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      body_q      <= '0;
    end else begin
      sig_prev_q  <= sig_edge;
      sync_d_q    <= sync_start;
      if (sync_d_q) armed_q <= 1'b1;
      hit_q       <= hit_d;
      pend_drop_q <= pend_drop_d;
      overflow_q  <= overflow_d;
      scan_id_q   <= scan_id_d;
      drop_cnt_q  <= drop_cnt_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      body_q      <= body_d;
    end
  end

endmodule

// File: tb/tb_scan_frame_packer.sv
// Directed + randomized bench: a scan/record reference model predicts every frame byte.
module tb_scan_frame_packer;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, sync_start, sig_edge, tx_ready;
  logic [31:0] sig_time;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [3:0]  fifo_level;
  logic [15:0] drop_count;
  logic        overflow;

  always #5 clk = ~clk;

  scan_frame_packer #(
    .FIFO_DEPTH (DEPTH),
    .TS_W       (32),
    .ID_W       (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sync_start (sync_start),
    .sig_edge   (sig_edge),
    .sig_time   (sig_time),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .fifo_level (fifo_level),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  typedef struct packed {
    logic [7:0]  flags;
    logic [15:0] id;
    logic [31:0] ts;
  } rec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state
  rec_t        exp_q[$];
  int          edge_cyc[$];
  bit          m_armed, m_snap_pend, m_hit_pend, m_prev_edge, m_pend_drop, m_ovf;
  int          m_last_sync;
  logic [15:0] m_id;
  int          m_drops;
  int          m_accepted = 0;

  // frame collector
  logic [7:0]  rx_buf[9];
  int          rx_cnt = 0;
  int          frames_rx = 0;
  bit          prev_stall;
  logic [7:0]  prev_data;
  logic [7:0]  last_csum, last_flags;
  logic [15:0] last_id;
  int          lat_watch = -1;
  int          lat_cyc = -1;
  int          zeros = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    edge_cyc.delete();
    m_armed = 0; m_snap_pend = 0; m_hit_pend = 0; m_prev_edge = 0;
    m_pend_drop = 0; m_ovf = 0; m_last_sync = cyc; m_id = '0; m_drops = 0;
    rx_cnt = 0; prev_stall = 0;
  endtask

  // A scan owns rising edges in (previous sync cycle, this sync cycle]; the record is
  // taken one cycle after sync with the sig_time present then.
  task automatic model_cycle(input bit s, input bit e);
    rec_t r;
    if (e && !m_prev_edge) edge_cyc.push_back(cyc);
    m_prev_edge = e;
    if (m_snap_pend) begin
      m_snap_pend = 0;
      if (!m_armed) m_armed = 1;
      else begin
        // head record sits in the serializer, so the FIFO is full at DEPTH+1 outstanding
        if (exp_q.size() > DEPTH) begin
          m_drops     = (m_drops == 65535) ? m_drops : m_drops + 1;
          m_ovf       = 1;
          m_pend_drop = 1;
        end else begin
          r.flags = {6'b0, m_pend_drop, m_hit_pend};
          r.id    = m_id;
          r.ts    = sig_time;
          exp_q.push_back(r);
          m_accepted++;
          m_pend_drop = 0;
        end
        m_id = m_id + 16'd1;
      end
    end
    if (s) begin
      m_hit_pend = 0;
      foreach (edge_cyc[k]) if (edge_cyc[k] > m_last_sync && edge_cyc[k] <= cyc) m_hit_pend = 1;
      edge_cyc.delete();
      m_last_sync = cyc;
      m_snap_pend = 1;
    end
  endtask

  task automatic compare_frame(input rec_t r);
    logic [7:0] e[9];
    e[0] = 8'hA5; e[1] = r.flags; e[2] = r.id[15:8]; e[3] = r.id[7:0];
    e[4] = r.ts[31:24]; e[5] = r.ts[23:16]; e[6] = r.ts[15:8]; e[7] = r.ts[7:0];
    e[8] = '0;
    for (int i = 0; i < 8; i++) e[8] ^= e[i];
    for (int i = 0; i < 9; i++) check($sformatf("frame%0d_B%0d", frames_rx, i), 32'(rx_buf[i]), 32'(e[i]));
  endtask

  task automatic collect();
    rec_t r;
    if (prev_stall) begin
      check("hold_valid", 32'(tx_valid), 32'd1);
      check("hold_data", 32'(tx_data), 32'(prev_data));
    end
    if (tx_valid && lat_watch >= 0) begin
      lat_cyc   = cyc - lat_watch;
      lat_watch = -1;
    end
    if (tx_valid && tx_ready) begin
      if (rx_cnt == 0) check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
      rx_buf[rx_cnt] = tx_data;
      rx_cnt++;
      if (rx_cnt == 9) begin
        rx_cnt = 0;
        frames_rx++;
        last_csum  = rx_buf[8];
        last_flags = rx_buf[1];
        last_id    = {rx_buf[2], rx_buf[3]};
        if (exp_q.size() > 0) begin
          r = exp_q.pop_front();
          compare_frame(r);
        end
      end
    end
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
  endtask

  task automatic step(input bit s, input bit e, input bit rdy, input bit rst);
    reset = rst; sync_start = s; sig_edge = e; tx_ready = rdy;
    @(negedge clk);
    if (rst) model_reset();
    else begin
      collect();
      model_cycle(s, e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic bit rnd_ready();
    bit b;
    b = (zeros >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
    zeros = b ? 0 : zeros + 1;
    return b;
  endfunction

  task automatic idle(input int n, input bit rdy);
    repeat (n) step(0, 0, rdy, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (exp_q.size() != 0 || rx_cnt != 0); k++) step(0, 0, 1, 0);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int f0;
    sig_time = 32'h0000_1234;
    model_reset();
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // first sync only arms; one edge pulse in the scan; second sync emits a frame
    step(1, 0, 1, 0);
    idle(5, 1);
    step(0, 1, 1, 0);
    idle(5, 1);
    lat_watch = cyc;
    step(1, 0, 1, 0);
    idle(25, 1);
    check("t1_frames", 32'(frames_rx), 32'd1);
    check("t1_latency", 32'(lat_cyc), 32'd3);
    check("t1_csum", 32'(last_csum), 32'h82);

    // two quiet scans with a stale timestamp
    step(1, 0, 1, 0); idle(15, 1);
    step(1, 0, 1, 0); idle(15, 1);
    check("t2_frames", 32'(frames_rx), 32'd3);
    check("t2_last_id", 32'(last_id), 32'd2);
    check("t2_flags", 32'(last_flags), 32'd0);

    // edge rising with sync_start belongs to the ending scan
    step(1, 1, 1, 0); idle(15, 1);
    check("t3_coincident_hit", 32'(last_flags), 32'd1);
    step(1, 0, 1, 0); idle(15, 1);
    check("t3_next_no_hit", 32'(last_flags), 32'd0);

    // randomized scans with random edges, timestamps and backpressure
    for (int s = 0; s < 8; s++) begin
      sig_time = $urandom;
      step(1, 1'($urandom_range(0, 1)), rnd_ready(), 0);
      for (int k = 0; k < 44; k++) begin
        if ($urandom_range(0, 15) == 0) sig_time = $urandom;
        step(0, ($urandom_range(0, 3) == 0), rnd_ready(), 0);
      end
    end
    drain();
    check("rand_frames_total", 32'(frames_rx), 32'(m_accepted));

    // stalled link: 10 armed syncs, one record held by the serializer, FIFO fills, rest dropped
    sig_time = 32'hCAFE_0001;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    idle(3, 0);
    for (int k = 0; k < 10; k++) begin
      sig_time = sig_time + 32'd1;
      step(1, 0, 0, 0);
      idle(3, 0);
    end
    check("stall_level_model", 32'(fifo_level), 32'(exp_q.size() - 1));
    check("stall_level_full", 32'(fifo_level), DEPTH);
    check("stall_drops", 32'(drop_count), 32'(m_drops));
    check("stall_overflow", 32'(overflow), 32'(m_ovf));
    f0 = frames_rx;
    drain();
    check("stall_frames_out", 32'(frames_rx - f0), 32'd9);
    step(1, 0, 1, 0); idle(20, 1);
    check("gap_flag", 32'(last_flags), 32'd2);
    check("gap_id", 32'(last_id), 32'd10);
    check("gap_overflow_sticky", 32'(overflow), 32'd1);

    // reset while byte B4 is on the bus, with a second record still queued
    step(1, 0, 1, 0);
    idle(2, 1);
    step(1, 0, 1, 0);
    for (int k = 0; k < 40 && rx_cnt != 4; k++) step(0, 0, 1, 0);
    check("reach_B4", 32'(rx_cnt), 32'd4);
    check("pre_rst_level", 32'(fifo_level), 32'(exp_q.size() - 1));
    f0 = frames_rx;
    step(0, 0, 1, 1);
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrst_fifo_level", 32'(fifo_level), 32'd0);
    check("midrst_drop_count", 32'(drop_count), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    idle(3, 1);
    step(1, 0, 1, 0); idle(15, 1);
    check("midrst_arm_no_frame", 32'(frames_rx - f0), 32'd0);
    step(1, 0, 1, 0); idle(15, 1);
    check("midrst_one_frame", 32'(frames_rx - f0), 32'd1);
    check("midrst_id0", 32'(last_id), 32'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
